// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle; sign fixup in a final cycle.
module mips_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // acc: product high half / partial remainder; wrk: multiplier / dividend-quotient
    logic [WIDTH-1:0]  acc_q, acc_d, wrk_q, wrk_d, dvs_q, dvs_d;
    logic              is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d;
    logic              dbz_pend_q, dbz_pend_d, dbz_q, dbz_d, done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic              is_signed;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    sum, mul_nxt, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && opA[WIDTH-1]) ? -opA : opA;
    assign b_mag     = (is_signed && opB[WIDTH-1]) ? -opB : opB;
    assign sum       = {1'b0, acc_q} + {1'b0, dvs_q};
    assign mul_nxt   = wrk_q[0] ? sum : {1'b0, acc_q};
    assign shifted   = {acc_q, wrk_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign prod      = {acc_q, wrk_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        wrk_d      = wrk_q;
        dvs_d      = dvs_q;
        is_div_d   = is_div_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !op[2]) begin
                    state_d    = StCalc;
                    cnt_d      = '0;
                    acc_d      = '0;
                    is_div_d   = op[1];
                    wrk_d      = op[1] ? a_mag : b_mag;
                    dvs_d      = op[1] ? b_mag : a_mag;
                    negq_d     = is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    negr_d     = is_signed & opA[WIDTH-1];
                    dbz_pend_d = op[1] & (opB == '0);
                    dbz_d      = 1'b0;
                end else if (start && op == 3'b100) begin
                    hi_d = opA;
                end else if (start && op == 3'b101) begin
                    lo_d = opA;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    // Restoring step: keep the difference only when it did not borrow
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_nxt[WIDTH:1];
                    wrk_d = {mul_nxt[0], wrk_q[WIDTH-1:1]};
                end
                if (cnt_q == LastCnt) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Zero divisor leaves |opA| as remainder, so the fixup restores opA
                    lo_d  = dbz_pend_q ? '1 : (negq_q ? -wrk_q : wrk_q);
                    hi_d  = negr_q ? -acc_q : acc_q;
                    dbz_d = dbz_pend_q;
                end else begin
                    {hi_d, lo_d} = negq_q ? -prod : prod;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            wrk_q      <= '0;
            dvs_q      <= '0;
            is_div_q   <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wrk_q      <= wrk_d;
            dvs_q      <= dvs_d;
            is_div_q   <= is_div_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv with a cycle-level arithmetic reference model.
module tb_mips_muldiv;

    localparam int unsigned WIDTH = 32;

    logic              clk, rst_n, start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  opA, opB;
    logic              busy, done, div_by_zero;
    logic [WIDTH-1:0]  hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mips_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {dbz, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] calc(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd0: begin p = longint'(sa * sb); return {1'b0, p}; end
            3'd1: begin p = ua * ub; return {1'b0, p}; end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
                else begin q = longint'(ua / ub); r = longint'(ua % ub); end
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_done, m_dbz, m_dbzp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_res <= '0;
            m_done <= 1'b0; m_dbz <= 1'b0; m_dbzp <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start && op < 3'd4) begin
                    m_cnt <= WIDTH + 1;
                    {m_dbzp, m_res} <= calc(op, opA, opB);
                    m_dbz <= 1'b0;
                end else if (start && op == 3'd4) begin
                    m_hi <= opA;
                end else if (start && op == 3'd5) begin
                    m_lo <= opA;
                end
            end else if (m_cnt == 1) begin
                {m_hi, m_lo} <= m_res;
                m_dbz  <= m_dbzp;
                m_done <= 1'b1;
                m_cnt  <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", {63'h0, busy}, {63'h0, m_cnt != 0});
        check("model_done", {63'h0, done}, {63'h0, m_done});
        check("model_dbz", {63'h0, div_by_zero}, {63'h0, m_dbz});
        check("model_hilo", {hi, lo}, {m_hi, m_lo});
    end

    // Drive a request now (caller sits at a negedge); returns at the next negedge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opA = a; opB = b;
        @(negedge clk);
        start = 1'b0; opA = $urandom; opB = $urandom;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {63'h0, done}, 64'h1);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        issue(o, a, b);
        wait_done();
        check(name, {hi, lo}, {eh, el});
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, div_by_zero, 29'h0, hi ^ lo, hi | lo}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -3 * 7 with exact busy/done timing
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult_busy_c1", {63'h0, busy}, 64'h1);
        repeat (32) @(negedge clk);
        check("mult_busy_c33", {62'h0, busy, done}, 64'h2);
        @(negedge clk);
        check("mult_done_c34", {62'h0, busy, done}, 64'h1);
        check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("multu_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", 3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);

        run_op("divu_by0", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        check("dbz_at_done", {63'h0, div_by_zero}, 64'h1);
        repeat (3) @(negedge clk);
        check("dbz_sticky", {63'h0, div_by_zero}, 64'h1);
        issue(3'd1, 32'h0000_0002, 32'h0000_0003);
        check("dbz_cleared", {63'h0, div_by_zero}, 64'h0);
        wait_done();
        check("multu_2_3", {hi, lo}, 64'h0000_0000_0000_0006);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_by0_s", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Requests while busy must be ignored
        issue(3'd1, 32'h0000_0005, 32'h0000_0006);
        @(negedge clk);
        start = 1'b1; op = 3'd4; opA = 32'h1234_5678;
        @(negedge clk);
        op = 3'd2; opA = 32'h0000_0064; opB = 32'h0000_0007;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("busy_ignore", {hi, lo}, 64'h0000_0000_0000_001E);
        issue(3'd5, 32'hAAAA_5555, 32'h0);
        check("mtlo_done_cycle", {busy, 31'h0, lo}, 64'h0000_0000_AAAA_5555);
        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        check("reserved_op", {busy, 31'h0, lo}, 64'h0000_0000_AAAA_5555);

        // Async reset in the middle of a DIV
        issue(3'd2, 32'h0000_0064, 32'h0000_0007);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", {busy, done, 30'h0, hi | lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", 64'(seen), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit with HI/LO result registers; it extends the single-cycle datapath ALU with MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU. Operands come from register-file readData1 (opA) and readData2 (opB).
- The controller stalls the PC while busy is high. It reads hi/lo for MFHI/MFLO.
- Operand width is parametrised. Latency is WIDTH+2 cycles from start accept to done.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal values are 4 or greater).

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only on an edge where busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- opA  input  WIDTH  multiplicand/dividend, or data for MTHI/MTLO
- opB  input  WIDTH  multiplier/divisor
- busy  output  1  high while an iterative operation is in flight
- done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle
- div_by_zero  output  1  sticky flag for the last DIV/DIVU with opB=0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low.
  - rst_n=0 immediately forces state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
  - Reset mid-operation aborts the operation. No done is produced.
- States: IDLE, CALC, FIX. busy=1 exactly in CALC and FIX.
- IDLE, start=1, op in 000..011:
  - Capture opA, opB, op and signedness on that edge (edge E0).
  - Clear div_by_zero and go to CALC with counter=0.
  - Signed ops convert operands to magnitudes at capture and record the result signs.
- IDLE, start=1, op=100/101: write opA into hi/lo respectively on that edge. No busy, no done, div_by_zero unchanged.
- IDLE, start=1, op=110/111: ignored; no register changes.
- start while busy=1: ignored regardless of op, including MTHI/MTLO. Captured operands are unaffected by input changes.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After WIDTH steps (edges E1..E_WIDTH), go to FIX.
- FIX (edge E_WIDTH+1): apply sign fixup, write hi/lo, set done=1 for the following cycle, return to IDLE.
  - busy=0 in the done cycle.
  - A new start in the done cycle is accepted (back-to-back throughput WIDTH+2).
- hi/lo keep their previous values through CALC/FIX. Intermediate values are never visible.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT, unsigned for MULTU.
- Divide results: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero. Signed remainder takes the sign of the dividend.
- Divide by zero (opB=0, DIV or DIVU): lo=all ones, hi=opA (as captured), div_by_zero=1 together with done. Latency is unchanged.
- Signed overflow (opA = most negative, opB = -1): lo = most negative, hi=0, div_by_zero=0.
- done is a registered output and is deasserted on the next edge.
- div_by_zero holds until the next accepted MULT/MULTU/DIV/DIVU.
- Counter width is clog2(WIDTH+1). No wrap is possible because the counter is cleared on accept.

Test Plan (WIDTH=32):
- MULT, opA=FFFFFFFD (-3), opB=00000007 -> busy high cycles 1..33 after accept; done in cycle 34; hi=FFFFFFFF, lo=FFFFFFEB.
- MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001. MULT with the same operands -> hi=00000000, lo=00000001.
- DIV FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 00000007/00000002 -> lo=00000003, hi=00000001.
- Divide by zero: DIVU 00000007/0 -> lo=FFFFFFFF, hi=00000007, div_by_zero=1, still set after done. A following MULTU clears it at accept.
- Signed overflow: DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
- Busy/reset handling:
  - Start MULTU 5*6; during busy, pulse start with MTHI opA=12345678 and with DIV -> both ignored; result hi=0, lo=0000001E.
  - Then MTLO AAAA5555 in the done cycle -> lo=AAAA5555 next cycle, no busy.
  - Drop rst_n at cycle 10 of a DIV -> hi=lo=0, busy=0, and no done ever pulses.
